// File: rtl/i2s_meter_pkg.sv
// Shared types and helpers for the I2S level meter: FSM states, MSB search and the log-scale bar.
package i2s_meter_pkg;

  typedef enum logic [1:0] {WAIT, SKIP, SHIFT, EVAL} state_e;

  // Index of the highest set bit, or -1 when the value is zero.
  function automatic int msb_index(input logic [63:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < 64; i++)
      if (v[i]) idx = i;
    return idx;
  endfunction

  // bar[k] lights when msb >= w_in-1-(w_bar-k)*db_step; thresholds below bit 0 are always met.
  function automatic logic [63:0] thermometer(input int msb, input int w_in,
                                              input int w_bar, input int db_step);
    logic [63:0] t;
    t = '0;
    for (int k = 0; k < 64; k++)
      if (msb >= 0 && k < w_bar && msb >= w_in - 1 - (w_bar - k) * db_step) t[k] = 1'b1;
    return t;
  endfunction

endpackage

// File: rtl/i2s_edge_det.sv
// Detects bclk rising edges and any lrclk transition observed at those edges.
module i2s_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic bclk,
  input  logic lrclk,
  output logic bclk_rise,
  output logic lr_edge,
  output logic lr_level
);

  logic bclk_q;
  logic lr_last_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_q    <= 1'b0;
      lr_last_q <= 1'b0;
    end else begin
      bclk_q <= bclk;
      if (bclk_rise) lr_last_q <= lrclk;
    end
  end

  assign bclk_rise = bclk & ~bclk_q;
  assign lr_edge   = bclk_rise & (lrclk ^ lr_last_q);
  assign lr_level  = lrclk;

endmodule

// File: rtl/i2s_level_meter.sv
// Bit-serial I2S peak meter: captures one channel, tracks |sample| peak per window, drives bar/clip.
module i2s_level_meter
  import i2s_meter_pkg::*;
#(
  parameter int w_in       = 24,
  parameter int w_bar      = 6,
  parameter int db_step    = 3,
  parameter int n_window   = 4800,
  parameter bit channel    = 1'b0,
  parameter bit offset_one = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bclk,
  input  logic             lrclk,
  input  logic             sd,
  output logic [w_in-2:0]  peak,
  output logic [w_bar-1:0] bar,
  output logic             clip,
  output logic             valid
);

  localparam int              BCW     = $clog2(w_in + 1);
  localparam int              WCW     = $clog2(n_window + 1);
  localparam logic [BCW-1:0]  BITS    = BCW'(w_in);
  localparam logic [WCW-1:0]  LAST    = WCW'(n_window - 1);
  localparam logic [w_in-2:0] MAX_ABS = '1;

  logic             bclk_rise, lr_edge, lr_level, word_start;
  state_e           state_q, state_d;
  logic [w_in-1:0]  shift_q, shift_d, neg_s, bit_mask;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]   win_cnt_q, win_cnt_d;
  logic [w_in-2:0]  run_peak_q, run_peak_d, abs_s, peak_upd, peak_q, peak_d;
  logic             clip_run_q, clip_run_d, clip_upd, clip_q, clip_d, valid_q, valid_d;
  logic [w_bar-1:0] bar_q, bar_d;

  i2s_edge_det u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .bclk_rise (bclk_rise),
    .lr_edge   (lr_edge),
    .lr_level  (lr_level)
  );

  assign word_start = lr_edge && (lr_level == channel);
  // Bits land MSB first at their final position, so a short word is already left-aligned.
  assign bit_mask   = w_in'(sd) << (BITS - BCW'(1) - bit_cnt_q);

  // The most negative code has no positive twin and saturates to full scale.
  assign neg_s    = ~shift_q + w_in'(1);
  assign abs_s    = !shift_q[w_in-1] ? shift_q[w_in-2:0]
                  : (neg_s[w_in-1] ? MAX_ABS : neg_s[w_in-2:0]);
  assign peak_upd = (abs_s > run_peak_q) ? abs_s : run_peak_q;
  assign clip_upd = clip_run_q | (abs_s == MAX_ABS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT:    if (word_start) state_d = offset_one ? SKIP : SHIFT;
      SKIP:    if (bclk_rise) state_d = SHIFT;
      SHIFT:   if (lr_edge) state_d = EVAL;
      EVAL:    state_d = WAIT;
      default: state_d = WAIT;
    endcase
  end

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    win_cnt_d  = win_cnt_q;
    run_peak_d = run_peak_q;
    clip_run_d = clip_run_q;
    peak_d     = peak_q;
    bar_d      = bar_q;
    clip_d     = clip_q;
    valid_d    = 1'b0;
    case (state_q)
      WAIT: if (word_start) begin
        shift_d   = offset_one ? '0 : {sd, {(w_in-1){1'b0}}};
        bit_cnt_d = offset_one ? '0 : BCW'(1);
      end
      SKIP, SHIFT: if (bclk_rise && bit_cnt_q < BITS) begin
        shift_d   = shift_q | bit_mask;
        bit_cnt_d = bit_cnt_q + BCW'(1);
      end
      EVAL: begin
        if (win_cnt_q == LAST) begin
          peak_d     = peak_upd;
          clip_d     = clip_upd;
          bar_d      = w_bar'(thermometer(msb_index(64'(peak_upd)), w_in, w_bar, db_step));
          valid_d    = 1'b1;
          run_peak_d = '0;
          clip_run_d = 1'b0;
          win_cnt_d  = '0;
        end else begin
          run_peak_d = peak_upd;
          clip_run_d = clip_upd;
          win_cnt_d  = win_cnt_q + WCW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      win_cnt_q  <= '0;
      run_peak_q <= '0;
      clip_run_q <= 1'b0;
      peak_q     <= '0;
      bar_q      <= '0;
      clip_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      win_cnt_q  <= win_cnt_d;
      run_peak_q <= run_peak_d;
      clip_run_q <= clip_run_d;
      peak_q     <= peak_d;
      bar_q      <= bar_d;
      clip_q     <= clip_d;
      valid_q    <= valid_d;
    end
  end

  assign peak  = peak_q;
  assign bar   = bar_q;
  assign clip  = clip_q;
  assign valid = valid_q;

endmodule
